// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: FIFO-buffered command issuer for a fixed-latency 8-bit ALU with held valid/ready responses.
// Define ALU_SEQ_OPCHK_EN to answer opcodes above 4'b1010 with an error response instead of issuing them.
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [3:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_res,
    input  logic       alu_cr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_cr,
    output logic       rsp_err,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ALU_LAT > 0 ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PONE = AW'(1);
    localparam logic [CW-1:0] LAT = CW'(ALU_LAT);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t state, state_next;
    logic [19:0] mem [DEPTH];
    logic [19:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [CW-1:0] cnt;
    logic push, pop, issue, reject, capture, bad_op;

    assign cmd_ready = count != FULL;
    assign push = cmd_valid & cmd_ready;
    assign head = mem[rd_ptr];
    assign busy = (count != '0) || (state != IDLE);

`ifdef ALU_SEQ_OPCHK_EN
    assign bad_op = head[3:0] > 4'b1010;
`else
    assign bad_op = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pop = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop = 1'b1;
                state_next = bad_op ? HOLD : WAIT;
            end
            WAIT: if (cnt == '0) begin
                capture = 1'b1;
                state_next = HOLD;
            end
            HOLD: state_next = rsp_ready ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
        issue = pop & ~bad_op;
        reject = pop & bad_op;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop) rd_ptr <= rd_ptr + PONE;
            count <= (push && !pop) ? count + CONE : (pop && !push) ? count - CONE : count;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end

    // ALU inputs only move on a real issue, so the ALU never sees intermediate values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_op <= '0;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_cr <= 1'b0;
        end else begin
            if (issue) {alu_a, alu_b, alu_op} <= head;
            cnt <= issue ? LAT : (state == WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
            rsp_data <= capture ? alu_res : reject ? 8'h00 : rsp_data;
            rsp_cr <= capture ? alu_cr : reject ? 1'b0 : rsp_cr;
            rsp_valid <= (capture | reject) ? 1'b1 : (state == HOLD && rsp_ready) ? 1'b0 : rsp_valid;
        end
    end

`ifdef ALU_SEQ_OPCHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsp_err <= 1'b0;
        else rsp_err <= reject ? 1'b1 : capture ? 1'b0 : rsp_err;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized and directed checks of alu_cmd_sequencer against a queue-based reference.
// A registered stand-in ALU (latency 1) drives alu_res/alu_cr; define ALU_SEQ_OPCHK_EN to cover opcode rejection.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] cmd_op = '0;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [3:0] alu_op;
    logic alu_cr;
    logic rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic rsp_cr, rsp_err, busy;

    int tests = 0, fails = 0;
    int n_push = 0, n_rsp = 0, n_disc = 0;
    logic last_push = 1'b0;
    logic rand_rdy = 1'b0, sweep_on = 1'b0;
    logic [3:0] prev_op = '0;
    int sweep_idx = 0;
    logic [19:0] exp_q[$];
    logic [9:0] got_q[$];

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_cr(alu_cr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cr(rsp_cr), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0: return {1'b0, a} + {1'b0, b};
            4'd1: return {1'b0, a} - {1'b0, b};
            4'd2: return {1'b0, a & b};
            4'd3: return {1'b0, a | b};
            4'd4: return {1'b0, a ^ b};
            4'd5: return {1'b0, ~a};
            4'd6: return {a, 1'b0};
            4'd7: return {a[0], 1'b0, a[7:1]};
            4'd8: return {1'b0, a} + 9'd1;
            4'd9: return {1'b0, a} - 9'd1;
            4'd10: return {1'b0, b};
            default: return {1'b0, a ^ ~b};
        endcase
    endfunction

    always_ff @(posedge clk) {alu_cr, alu_res} <= alu_calc(alu_a, alu_b, alu_op);

    // expected {err, cr, data} for an accepted command {a, b, op}
    function automatic logic [9:0] exp_rsp(input logic [19:0] c);
`ifdef ALU_SEQ_OPCHK_EN
        if (c[3:0] > 4'd10) return 10'h200;
`endif
        return {1'b0, alu_calc(c[19:12], c[11:4], c[3:0])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_cmd();
        cmd_a = 8'($urandom);
        cmd_b = 8'($urandom);
        cmd_op = 4'($urandom);
    endtask

    task automatic tick();
        logic pushed, popped;
        @(negedge clk);
        pushed = rst && cmd_valid && cmd_ready;
        popped = rst && rsp_valid && rsp_ready;
        if (rst && rsp_valid) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rsp_value", {22'd0, rsp_err, rsp_cr, rsp_data}, {22'd0, exp_rsp(exp_q[0])});
        end
        if (popped && exp_q.size() != 0) begin
            got_q.push_back({rsp_err, rsp_cr, rsp_data});
            void'(exp_q.pop_front());
            n_rsp++;
        end
        if (pushed) begin
            exp_q.push_back({cmd_a, cmd_b, cmd_op});
            n_push++;
        end
        last_push = pushed;
`ifdef ALU_SEQ_OPCHK_EN
        chk("alu_op_legal", 32'(alu_op <= 4'd10), 1);
`endif
        @(posedge clk);
        #1;
        if (sweep_on) begin
            if (alu_op !== prev_op) begin
                chk("sweep_op", 32'(alu_op), sweep_idx);
                sweep_idx++;
                prev_op = alu_op;
            end
            if (alu_a !== 8'h00) chk("sweep_ab", {16'd0, alu_a, alu_b}, 32'h0000AA55);
        end
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int i;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        for (i = 0; i < 60; i++) begin
            tick();
            if (last_push) break;
        end
        chk("push_accepted", 32'(last_push), 1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_alu"}, {12'd0, alu_a, alu_b, alu_op}, 0);
        chk({tag, "_rsp"}, {21'd0, rsp_valid, rsp_data, rsp_cr, rsp_err}, 0);
        chk({tag, "_ctl"}, {30'd0, busy, cmd_ready}, 32'd1);
    endtask

    task automatic fill(output int n);
        n = 0;
        rsp_ready = 1'b0;
        new_cmd();
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (last_push) begin
                n++;
                new_cmd();
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n, base;
        logic [10:0] snap;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b1;

        // single add: issue one edge after push, response two edges later
        rsp_ready = 1'b1;
        cmd_a = 8'hE3;
        cmd_b = 8'h7D;
        cmd_op = 4'b0000;
        cmd_valid = 1'b1;
        tick();
        chk("t2_push", 32'(last_push), 1);
        cmd_valid = 1'b0;
        tick();
        chk("t2_issue", {12'd0, alu_a, alu_b, alu_op}, 32'h000E37D0);
        tick();
        chk("t2_not_yet", 32'(rsp_valid), 0);
        tick();
        chk("t2_rsp", {22'd0, rsp_valid, rsp_cr, rsp_data}, 32'h360);
        tick();
        chk("t2_done", 32'(rsp_valid), 0);

        // back-pressure: one held plus DEPTH queued
        base = n_rsp;
        fill(n);
        chk("t3_accepted", n, 5);
        chk("t3_full", 32'(cmd_ready), 0);
        snap = {rsp_valid, rsp_err, rsp_cr, rsp_data};
        repeat (3) tick();
        chk("t3_stable", {21'd0, rsp_valid, rsp_err, rsp_cr, rsp_data}, {21'd0, snap});
        rsp_ready = 1'b1;
        tick();
        chk("t3_ready_before_pop", 32'(cmd_ready), 0);
        tick();
        chk("t3_ready_after_pop", 32'(cmd_ready), 1);
        drain();
        chk("t3_rsp_count", n_rsp - base, 5);

        // async reset with one command in WAIT and three queued
        fill(n);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("t1_queued", {30'd0, busy, cmd_ready}, 32'd3);
        #2 rst = 1'b0;
        n_disc += exp_q.size();
        exp_q.delete();
        #1 check_reset("t1_async");
        tick();
        tick();
        check_reset("t1_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t1_quiet", {30'd0, rsp_valid, busy}, 0);
        end

        // opcode sweep, back-to-back, operands constant
        rsp_ready = 1'b1;
        prev_op = alu_op;
        sweep_idx = (alu_op == 4'd0) ? 1 : 0;
        sweep_on = 1'b1;
        for (int op = 0; op <= 10; op++) push(8'hAA, 8'h55, 4'(op));
        drain();
        repeat (2) tick();
        sweep_on = 1'b0;
        chk("t4_sweep_len", sweep_idx, 11);

        // random response back-pressure
        rand_rdy = 1'b1;
        push(8'h7D, 8'hE3, 4'b0101);
        push(8'hE3, 8'hE3, 4'b0101);
        push(8'hE3, 8'hE3, 4'b1001);
        drain();

`ifdef ALU_SEQ_OPCHK_EN
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        push(8'h12, 8'h34, 4'b1111);
        push(8'h01, 8'h01, 4'b0000);
        drain();
        chk("t6_reject", 32'(got_q[got_q.size() - 2]), 32'h200);
        chk("t6_legal", 32'(got_q[got_q.size() - 1]), 32'h002);
        rand_rdy = 1'b1;
`endif

        // random commands with random gaps and random response readiness
        for (int i = 0; i < 40; i++) begin
            new_cmd();
            push(cmd_a, cmd_b, cmd_op);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        chk("idle_end", {30'd0, busy, rsp_valid}, 0);
        chk("totals", n_rsp + n_disc, n_push);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
